// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a small TX FIFO.
//
// Register map (word addresses relative to BASE_ADDR):
//   +0 DATA   store pushes wr_data[7:0] into the FIFO (dropped + overflow if full)
//   +4 STATUS load: [0]empty [1]full [2]busy [3]irq_enable [4]irq_pending
//                   [5]overflow [11:8]count; stores ignored
//   +8 CTRL   store: [0]irq_enable, [1]=1 acks irq_pending, [2]=1 clears overflow
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-low reset
//   address, wr_data   bus address and store data
//   MemRead, MemWrite  load / store strobes
//   UartAddress        combinational: strobe active and address hits a register
//   rd_data            combinational load data (0 unless STATUS is read)
//   tx                 registered serial line, idle high
//   TxInterrupt        irq_pending & irq_enable
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF0100,
    parameter int          DEPTH        = 4,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] wr_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic        UartAddress,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        TxInterrupt
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CCW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nx;
    logic [CCW-1:0]   cyc;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tx_nx;
    logic             pop, done;

    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [3:0]       cnt4;
    logic             empty, full, busy, bit_last;
    logic             irq_enable, irq_pending, overflow;

    logic             sel_data, sel_stat, sel_ctrl;
    logic             wr_push, wr_ctrl, push_ok, ovf_set;
    logic             unused_ok;

    // ---------------- bus decode ----------------
    assign sel_data    = (address == BASE_ADDR);
    assign sel_stat    = (address == BASE_ADDR + 32'd4);
    assign sel_ctrl    = (address == BASE_ADDR + 32'd8);
    assign UartAddress = (MemRead | MemWrite) & (sel_data | sel_stat | sel_ctrl);
    assign wr_push     = MemWrite & sel_data;
    assign wr_ctrl     = MemWrite & sel_ctrl;
    assign unused_ok   = ^wr_data[31:8];

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign busy     = (state != IDLE);
    assign bit_last = (cyc == CCW'(CLKS_PER_BIT - 1));
    assign cnt4     = 4'(count);

    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted then; otherwise a push into a full FIFO is dropped.
    assign push_ok = wr_push & (~full | pop);
    assign ovf_set = wr_push & full & ~pop;

    always_comb begin
        rd_data = '0;
        if (MemRead && sel_stat)
            rd_data = {20'b0, cnt4, 2'b0, overflow, irq_pending, irq_enable,
                       busy, full, empty};
    end

    assign TxInterrupt = irq_pending & irq_enable;

    // ---------------- serializer FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // tx_nx is the line level for the current state; it is registered, so the
    // whole frame lags the state machine by one cycle.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        done     = 1'b0;
        tx_nx    = 1'b1;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                tx_nx = 1'b0;
                if (bit_last) state_nx = DATA;
            end
            DATA: begin
                tx_nx = shift[0];
                if (bit_last && bit_idx == 3'd7) state_nx = STOP;
            end
            STOP: begin
                tx_nx = 1'b1;
                if (bit_last) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        state_nx = START;
                    end else begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            tx <= tx_nx;
            if (state == IDLE || bit_last) cyc <= '0;
            else                           cyc <= cyc + 1'b1;

            if (state != DATA)  bit_idx <= '0;
            else if (bit_last)  bit_idx <= bit_idx + 3'd1;

            if (pop)                          shift <= mem[rd_ptr];
            else if (state == DATA && bit_last) shift <= shift >> 1;
        end
    end

    // ---------------- FIFO ----------------
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- control / status flags ----------------
    // A set event beats a software clear landing in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_enable  <= 1'b0;
            irq_pending <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (wr_ctrl) irq_enable <= wr_data[0];

            if (done)                      irq_pending <= 1'b1;
            else if (wr_ctrl && wr_data[1]) irq_pending <= 1'b0;

            if (ovf_set)                   overflow <= 1'b1;
            else if (wr_ctrl && wr_data[2]) overflow <= 1'b0;
        end
    end

endmodule
